// File: rtl/countdown5_pkg.sv
// Shared constants for the countdown5 timer: FSM encoding and default reset value.
// Backpressure: none; this package holds only declarations.
package countdown5_pkg;

  localparam int unsigned CD_WIDTH_DEF = 5;
  localparam logic [CD_WIDTH_DEF-1:0] CD_RESET_VAL_DEF = 5'h11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/countdown5.sv
// Loadable down-counter with one-shot/periodic reload and a registered zero pulse.
// Latency: outputs update on the clock edge after their inputs. Backpressure: none.
module countdown5
  import countdown5_pkg::*;
#(
  parameter int unsigned      WIDTH     = CD_WIDTH_DEF,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(CD_RESET_VAL_DEF)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             stop,
  input  logic             periodic,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             zero
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             zero_q, zero_d;
  logic             busy_q, busy_d;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    zero_d   = 1'b0;

    if (load) begin
      count_d  = load_val;
      reload_d = load_val;
      if (state_q == ST_RUN) begin
        if (load_val == '0) state_d = ST_IDLE;
      end else if (start && load_val != '0) begin
        state_d = ST_RUN;
      end
    end else if (stop) begin
      state_d = ST_IDLE;
    end else if (state_q == ST_RUN || (start && count_q != '0)) begin
      // A start from IDLE counts on the same edge, just like a RUN cycle.
      state_d = ST_RUN;
      if (count_q != '0) begin
        count_d = count_q - WIDTH'(1);
        if (count_q == WIDTH'(1)) begin
          zero_d = 1'b1;
          if (!periodic) state_d = ST_IDLE;
        end
      end else if (periodic) begin
        count_d = reload_q;
      end else begin
        state_d = ST_IDLE;
      end
    end

    busy_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      count_q  <= RESET_VAL;
      reload_q <= RESET_VAL;
      zero_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      zero_q   <= zero_d;
      busy_q   <= busy_d;
    end
  end

  assign count = count_q;
  assign busy  = busy_q;
  assign zero  = zero_q;

endmodule

// File: tb/tb_countdown5.sv
// Directed-vector bench for countdown5 with a timestamped scoreboard queue.
module tb_countdown5;

  logic       clk;
  logic       reset;
  logic       load;
  logic [4:0] load_val;
  logic       start;
  logic       stop;
  logic       periodic;
  logic [4:0] count;
  logic       busy;
  logic       zero;

  int cyc;
  int n_vec;
  int n_bad;

  typedef struct {
    int         due;
    logic [4:0] c;
    logic       b;
    logic       z;
  } exp_t;

  exp_t sb[$];

  countdown5 dut (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .start    (start),
    .stop     (stop),
    .periodic (periodic),
    .count    (count),
    .busy     (busy),
    .zero     (zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic step(input logic r, input logic ld, input logic [4:0] lv,
                      input logic st, input logic sp, input logic per,
                      input logic glitch,
                      input logic [4:0] ec, input logic eb, input logic ez);
    exp_t e;
    @(posedge clk);
    #1;
    reset = r; load = ld; load_val = lv; start = st; stop = sp; periodic = per;
    e.due = cyc + 1;
    e.c = ec;
    e.b = eb;
    e.z = ez;
    sb.push_back(e);
    if (glitch) begin
      reset = 1'b1;
      #2;
      reset = 1'b0;
    end
  endtask

  task automatic tick(input logic per, input logic [4:0] ec, input logic eb, input logic ez);
    step(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, per, 1'b0, ec, eb, ez);
  endtask

  // Monitor: compare every queued expectation in the cycle it falls due.
  initial begin
    exp_t e;
    n_vec = 0;
    n_bad = 0;
    forever begin
      @(posedge clk);
      #3;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        n_vec++;
        if (e.due < cyc) begin
          n_bad++;
          $display("FAIL missed_vector due=%0d now=%0d", e.due, cyc);
        end else if (count !== e.c || busy !== e.b || zero !== e.z) begin
          n_bad++;
          $display("FAIL cycle%0d got count=%0d busy=%b zero=%b want count=%0d busy=%b zero=%b",
                   cyc, count, busy, zero, e.c, e.b, e.z);
        end
      end
    end
  end

  initial begin
    reset = 1'b0; load = 1'b0; load_val = 5'd0;
    start = 1'b0; stop = 1'b0; periodic = 1'b0;

    // Reset for two cycles, then a single one-shot run 16..0.
    step(1, 0, 5'd0, 0, 0, 0, 0, 5'd17, 0, 0);
    step(1, 0, 5'd0, 0, 0, 0, 0, 5'd17, 0, 0);
    tick(0, 5'd17, 0, 0);
    step(0, 0, 5'd0, 1, 0, 0, 0, 5'd16, 1, 0);
    for (int i = 15; i >= 1; i--) tick(0, 5'(i), 1, 0);
    tick(0, 5'd0, 0, 1);
    tick(0, 5'd0, 0, 0);
    step(0, 0, 5'd0, 1, 0, 0, 0, 5'd0, 0, 0);

    // Periodic reload of 3: period of four cycles, zero every fourth.
    step(0, 1, 5'd3, 1, 0, 1, 0, 5'd3, 1, 0);
    for (int p = 0; p < 2; p++) begin
      tick(1, 5'd2, 1, 0);
      tick(1, 5'd1, 1, 0);
      tick(1, 5'd0, 1, 1);
      tick(1, 5'd3, 1, 0);
    end
    step(0, 0, 5'd0, 0, 1, 1, 0, 5'd3, 0, 0);

    // Stop at 10, hold, then resume.
    step(1, 0, 5'd0, 0, 0, 0, 0, 5'd17, 0, 0);
    step(0, 0, 5'd0, 1, 0, 0, 0, 5'd16, 1, 0);
    for (int i = 15; i >= 10; i--) tick(0, 5'(i), 1, 0);
    step(0, 0, 5'd0, 0, 1, 0, 0, 5'd10, 0, 0);
    tick(0, 5'd10, 0, 0);
    step(0, 0, 5'd0, 1, 0, 0, 0, 5'd9, 1, 0);
    tick(0, 5'd8, 1, 0);

    // Load 7 while running at 12; the new reload value appears after zero.
    step(1, 0, 5'd0, 0, 0, 1, 0, 5'd17, 0, 0);
    step(0, 0, 5'd0, 1, 0, 1, 0, 5'd16, 1, 0);
    for (int i = 15; i >= 12; i--) tick(1, 5'(i), 1, 0);
    step(0, 1, 5'd7, 0, 0, 1, 0, 5'd7, 1, 0);
    for (int i = 6; i >= 1; i--) tick(1, 5'(i), 1, 0);
    tick(1, 5'd0, 1, 1);
    tick(1, 5'd7, 1, 0);
    step(0, 0, 5'd0, 0, 1, 1, 0, 5'd7, 0, 0);

    // Load in IDLE without start; zero-valued loads never start or pulse.
    step(0, 1, 5'd9, 0, 0, 0, 0, 5'd9, 0, 0);
    step(0, 1, 5'd0, 1, 0, 0, 0, 5'd0, 0, 0);
    step(0, 0, 5'd0, 1, 0, 0, 0, 5'd0, 0, 0);
    step(0, 1, 5'd4, 1, 0, 0, 0, 5'd4, 1, 0);
    step(0, 1, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0);
    tick(0, 5'd0, 0, 0);

    // Reset mid-run at 5, then a reset pulse between edges is ignored.
    step(1, 0, 5'd0, 0, 0, 0, 0, 5'd17, 0, 0);
    step(0, 0, 5'd0, 1, 0, 0, 0, 5'd16, 1, 0);
    for (int i = 15; i >= 5; i--) tick(0, 5'(i), 1, 0);
    step(1, 0, 5'd0, 0, 0, 0, 0, 5'd17, 0, 0);
    step(0, 0, 5'd0, 1, 0, 0, 0, 5'd16, 1, 0);
    step(0, 0, 5'd0, 0, 0, 0, 1, 5'd15, 1, 0);
    tick(0, 5'd14, 1, 0);

    repeat (3) @(posedge clk);
    #5;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain left=%0d want=0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
